// File: rtl/decode_pipe_stage_if.sv
// rtl/decode_pipe_stage_if.sv - fetch-side and execute-side handshake bundle of the decode stage
interface decode_pipe_stage_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_rs1_data;
  logic [XLEN-1:0] out_rs2_data;
  logic [XLEN-1:0] out_imm;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic            out_funct7b5;
  logic [AW-1:0]   out_rd;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
           out_opcode, out_funct3, out_funct7b5, out_rd, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
           out_opcode, out_funct3, out_funct7b5, out_rd, out_illegal
  );
endinterface

// File: rtl/decode_pipe_stage.sv
// rtl/decode_pipe_stage.sv - RV32 decode stage with register file, forwarding and load-use stall
// Optional EX forwarding is enabled by defining DECODE_FWD_EN.
module decode_pipe_stage #(
  parameter int  XLEN     = 32,
  parameter int  NUM_REGS = 32,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 ex_rd_wen_i,
  input  logic [AW-1:0]        ex_rd_addr_i,
  input  logic                 ex_is_load_i,
  input  logic [XLEN-1:0]      ex_rd_data_i,
  input  logic                 wb_en_i,
  input  logic [AW-1:0]        wb_addr_i,
  input  logic [XLEN-1:0]      wb_data_i,
  decode_pipe_stage_if.slave   io
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [XLEN-1:0] rf_q [NUM_REGS];
  logic            out_valid_q;
  logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [6:0]      opcode_q;
  logic [2:0]      funct3_q;
  logic            funct7b5_q, illegal_q;
  logic [AW-1:0]   rd_q;

  logic [31:0]     instr;
  logic [4:0]      rs1_f, rs2_f, rd_f;
  logic [AW-1:0]   rs1_a, rs2_a;
  logic            use_rs1, use_rs2, wr_rd, known;
  logic [31:0]     imm32;
  logic [XLEN-1:0] rs1_data_d, rs2_data_d, imm_d;
  logic [AW-1:0]   rd_d;
  logic            illegal_d, stall, advance, accept;

  assign instr = io.in_instr;
  assign rs1_f = instr[19:15];
  assign rs2_f = instr[24:20];
  assign rd_f  = instr[11:7];
  assign rs1_a = rs1_f[AW-1:0];
  assign rs2_a = rs2_f[AW-1:0];

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    wr_rd   = 1'b0;
    known   = 1'b1;
    imm32   = 32'h0;
    case (instr[6:0])
      OP_LUI, OP_AUIPC: begin
        wr_rd = 1'b1;
        imm32 = {instr[31:12], 12'h0};
      end
      OP_JAL: begin
        wr_rd = 1'b1;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_IMM: begin
        use_rs1 = 1'b1;
        wr_rd   = 1'b1;
        imm32   = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        wr_rd   = 1'b1;
      end
      default: known = 1'b0;
    endcase
  end

  // An EX hit is the only source of a hazard; WB is always written through.
  function automatic logic ex_hit(input logic used, input logic [AW-1:0] a);
    return used && (a != '0) && ex_rd_wen_i && (ex_rd_addr_i == a);
  endfunction

  function automatic logic [XLEN-1:0] resolve(input logic used, input logic [AW-1:0] a);
    if (!used || a == '0)
      return '0;
`ifdef DECODE_FWD_EN
    if (ex_hit(used, a) && !ex_is_load_i)
      return ex_rd_data_i;
`endif
    if (wb_en_i && wb_addr_i == a)
      return wb_data_i;
    return rf_q[a];
  endfunction

`ifdef DECODE_FWD_EN
  assign stall = io.in_valid && ex_is_load_i && (ex_hit(use_rs1, rs1_a) || ex_hit(use_rs2, rs2_a));
`else
  assign stall = io.in_valid && (ex_hit(use_rs1, rs1_a) || ex_hit(use_rs2, rs2_a));
  logic unused_fwd;
  assign unused_fwd = ^{ex_rd_data_i, ex_is_load_i};
`endif

  assign rs1_data_d = resolve(use_rs1, rs1_a);
  assign rs2_data_d = resolve(use_rs2, rs2_a);
  assign imm_d      = XLEN'($signed(imm32));
  assign rd_d       = wr_rd ? rd_f[AW-1:0] : '0;
  assign illegal_d  = !known
                   || (use_rs1 && 32'(rs1_f) >= NUM_REGS)
                   || (use_rs2 && 32'(rs2_f) >= NUM_REGS)
                   || (wr_rd   && 32'(rd_f)  >= NUM_REGS);

  assign advance     = !out_valid_q || io.out_ready;
  assign accept      = io.in_valid && !stall;
  assign io.in_ready = flush_i || (advance && !stall);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      opcode_q    <= '0;
      funct3_q    <= '0;
      funct7b5_q  <= 1'b0;
      rd_q        <= '0;
      illegal_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      if (wb_en_i && wb_addr_i != '0)
        rf_q[wb_addr_i] <= wb_data_i;
      if (flush_i) begin
        out_valid_q <= 1'b0;
      end else if (advance) begin
        out_valid_q <= accept;
        if (accept) begin
          pc_q       <= io.in_pc;
          rs1_data_q <= rs1_data_d;
          rs2_data_q <= rs2_data_d;
          imm_q      <= imm_d;
          opcode_q   <= instr[6:0];
          funct3_q   <= instr[14:12];
          funct7b5_q <= instr[30];
          rd_q       <= rd_d;
          illegal_q  <= illegal_d;
        end
      end
    end
  end

  assign io.out_valid    = out_valid_q;
  assign io.out_pc       = pc_q;
  assign io.out_rs1_data = rs1_data_q;
  assign io.out_rs2_data = rs2_data_q;
  assign io.out_imm      = imm_q;
  assign io.out_opcode   = opcode_q;
  assign io.out_funct3   = funct3_q;
  assign io.out_funct7b5 = funct7b5_q;
  assign io.out_rd       = rd_q;
  assign io.out_illegal  = illegal_q;
endmodule

// File: tb/tb_decode_pipe_stage.sv
// tb/tb_decode_pipe_stage.sv - directed-vector bench for decode_pipe_stage
module tb_decode_pipe_stage;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [31:0] I_ADD_6_5_5  = 32'h0052_8333;
  localparam logic [31:0] I_ADD_10_7_0 = 32'h0003_8533;
  localparam logic [31:0] I_ADDI_9_8_M1 = 32'hFFF4_0493;
  localparam logic [31:0] I_LUI_3      = 32'h1234_51B7;
  localparam logic [31:0] I_SW_5_12_6  = 32'h0053_2623;
  localparam logic [31:0] I_JAL_1_M4   = 32'hFFDF_F0EF;
  localparam logic [31:0] I_BEQ_1_2_M8 = 32'hFE20_8CE3;
  localparam logic [31:0] I_CUSTOM     = 32'h0000_000B;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            ex_rd_wen, ex_is_load, wb_en;
  logic [AW-1:0]   ex_rd_addr, wb_addr;
  logic [XLEN-1:0] ex_rd_data, wb_data;
  int              n_vec  = 0;
  int              n_miss = 0;

  decode_pipe_stage_if #(.XLEN(XLEN), .AW(AW)) bus ();

  decode_pipe_stage #(.XLEN(XLEN), .NUM_REGS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .ex_rd_wen_i  (ex_rd_wen),
    .ex_rd_addr_i (ex_rd_addr),
    .ex_is_load_i (ex_is_load),
    .ex_rd_data_i (ex_rd_data),
    .wb_en_i      (wb_en),
    .wb_addr_i    (wb_addr),
    .wb_data_i    (wb_data),
    .io           (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    present(instr, pc);
    cycle();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    ex_rd_wen = 1'b0; ex_rd_addr = '0; ex_is_load = 1'b0; ex_rd_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_pc", bus.out_pc, 32'h0);
    check("rst_out_imm", bus.out_imm, 32'h0);
    check("rst_out_rd", 32'(bus.out_rd), 32'd0);

    for (int i = 1; i < 32; i++) begin
      issue((i << 20) | (i << 15) | (1 << 7) | 32'h33, 32'(i * 4));
      check($sformatf("rf_zero_x%0d", i), bus.out_rs1_data, 32'h0);
    end

    // writeback of x5 seen by the instruction decoded in the same cycle
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
    issue(I_ADD_6_5_5, 32'h40);
    wb_en = 1'b0;
    check("wt_valid", 32'(bus.out_valid), 32'd1);
    check("wt_rs1", bus.out_rs1_data, 32'h1234);
    check("wt_rs2", bus.out_rs2_data, 32'h1234);
    check("wt_rd", 32'(bus.out_rd), 32'd6);
    check("wt_opcode", 32'(bus.out_opcode), 32'h33);

    // ALU result in EX targeting x7
    ex_rd_wen = 1'b1; ex_rd_addr = 5'd7; ex_rd_data = 32'hA5; ex_is_load = 1'b0;
    present(I_ADD_10_7_0, 32'h44);
    #1;
`ifdef DECODE_FWD_EN
    check("fwd_in_ready", 32'(bus.in_ready), 32'd1);
    cycle();
    ex_rd_wen = 1'b0;
    check("fwd_valid", 32'(bus.out_valid), 32'd1);
    check("fwd_rs1", bus.out_rs1_data, 32'hA5);
`else
    check("nofwd_in_ready", 32'(bus.in_ready), 32'd0);
    cycle();
    check("nofwd_bubble", 32'(bus.out_valid), 32'd0);
    ex_rd_wen = 1'b0; wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hA5;
    #1;
    check("nofwd_in_ready2", 32'(bus.in_ready), 32'd1);
    cycle();
    wb_en = 1'b0;
    check("nofwd_valid", 32'(bus.out_valid), 32'd1);
    check("nofwd_rs1", bus.out_rs1_data, 32'hA5);
`endif
    bus.in_valid = 1'b0;
    check("add10_rd", 32'(bus.out_rd), 32'd10);
    check("add10_rs2", bus.out_rs2_data, 32'h0);

    // load-use on x8
    ex_rd_wen = 1'b1; ex_rd_addr = 5'd8; ex_is_load = 1'b1; ex_rd_data = 32'hDEAD;
    present(I_ADDI_9_8_M1, 32'h48);
    #1;
    check("lu_in_ready", 32'(bus.in_ready), 32'd0);
    cycle();
    check("lu_bubble", 32'(bus.out_valid), 32'd0);
    ex_rd_wen = 1'b0; ex_is_load = 1'b0; wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h10;
    #1;
    check("lu_in_ready2", 32'(bus.in_ready), 32'd1);
    cycle();
    bus.in_valid = 1'b0; wb_en = 1'b0;
    check("lu_valid", 32'(bus.out_valid), 32'd1);
    check("lu_rs1", bus.out_rs1_data, 32'h10);
    check("lu_imm", bus.out_imm, 32'hFFFF_FFFF);
    check("lu_rd", 32'(bus.out_rd), 32'd9);
    check("lu_rs2_unused", bus.out_rs2_data, 32'h0);

    // backpressure: LUI held while SW waits
    issue(I_LUI_3, 32'h100);
    bus.out_ready = 1'b0;
    present(I_SW_5_12_6, 32'h104);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      cycle();
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_pc", bus.out_pc, 32'h100);
      check("hold_imm", bus.out_imm, 32'h1234_5000);
      check("hold_rd", 32'(bus.out_rd), 32'd3);
    end
    bus.out_ready = 1'b1;
    #1;
    check("hold_release_ready", 32'(bus.in_ready), 32'd1);
    cycle();
    bus.in_valid = 1'b0;
    check("sw_pc", bus.out_pc, 32'h104);
    check("sw_imm", bus.out_imm, 32'd12);
    check("sw_rd", 32'(bus.out_rd), 32'd0);
    check("sw_funct3", 32'(bus.out_funct3), 32'd2);
    check("sw_rs2", bus.out_rs2_data, 32'h1234);
    check("sw_rs1", bus.out_rs1_data, 32'h0);

    // flush while the output is held and a JAL is offered
    issue(I_LUI_3, 32'h180);
    bus.out_ready = 1'b0;
    flush = 1'b1;
    present(I_JAL_1_M4, 32'h200);
    #1;
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    cycle();
    flush = 1'b0; bus.out_ready = 1'b1;
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    issue(I_BEQ_1_2_M8, 32'h208);
    check("beq_valid", 32'(bus.out_valid), 32'd1);
    check("beq_pc", bus.out_pc, 32'h208);
    check("beq_imm", bus.out_imm, 32'hFFFF_FFF8);
    check("beq_rd", 32'(bus.out_rd), 32'd0);

    issue(I_JAL_1_M4, 32'h300);
    check("jal_imm", bus.out_imm, 32'hFFFF_FFFC);
    check("jal_rd", 32'(bus.out_rd), 32'd1);
    check("jal_illegal", 32'(bus.out_illegal), 32'd0);
    issue(I_CUSTOM, 32'h304);
    check("custom_illegal", 32'(bus.out_illegal), 32'd1);
    check("custom_rd", 32'(bus.out_rd), 32'd0);
    bus.in_instr = I_CUSTOM;
    cycle();
    check("idle_no_valid", 32'(bus.out_valid), 32'd0);

    // reset while holding a payload
    issue(I_SW_5_12_6, 32'h400);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0; bus.out_ready = 1'b1;
    #1;
    check("rst_hold_valid", 32'(bus.out_valid), 32'd0);
    check("rst_hold_pc", bus.out_pc, 32'h0);
    issue(I_ADD_6_5_5, 32'h404);
    check("rst_rf_cleared", bus.out_rs1_data, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
